// File: rtl/div_multi_ch_if.sv
// rtl/div_multi_ch_if.sv - control and output bundle for the multi-channel clock divider
interface div_multi_ch_if #(
    parameter int WIDE = 16,
    parameter int CH   = 4
);
    logic                 iEN;
    logic [CH*WIDE-1:0]   iDIV;
    logic [CH-1:0]        iLOAD;
    logic [CH-1:0]        oCLK;
    logic [CH-1:0]        oTICK;

    modport master (output iEN, iDIV, iLOAD, input oCLK, oTICK);
    modport slave  (input iEN, iDIV, iLOAD, output oCLK, oTICK);
endinterface

// File: rtl/div_multi_ch.sv
// rtl/div_multi_ch.sv - multi-channel runtime-divisor clock divider with glitch-free reload
module div_multi_ch #(
    parameter int WIDE        = 16,
    parameter int CH          = 4,
    parameter int DEFAULT_DIV = 2
) (
    input  logic          iCLK,
    input  logic          iRST,
    div_multi_ch_if.slave bus
);
    localparam logic [WIDE-1:0] DEF   = WIDE'(DEFAULT_DIV);
    localparam logic [WIDE-1:0] ONE   = WIDE'(1);
    localparam logic [WIDE:0]   ONE_X = (WIDE+1)'(1);

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [WIDE-1:0] r_cnt, r_act, r_pend;
        logic            r_pv, r_clk, r_tick;

        logic [WIDE-1:0] w_slice, w_pend_in;
        logic            w_pv_in, w_wrap, w_start;
        logic [WIDE-1:0] w_nxt_cnt, w_nxt_act;
        logic            w_nxt_pv, w_nxt_tick, w_nxt_clk;
        logic [WIDE:0]   w_nxt_half;

        assign w_slice   = bus.iDIV[c*WIDE +: WIDE];
        assign w_pend_in = bus.iLOAD[c] ? w_slice : r_pend;
        assign w_pv_in   = bus.iLOAD[c] | r_pv;
        assign w_wrap    = (r_act != '0) && (r_cnt == r_act - ONE);
        // A stopped channel has no wrap; a pending divisor restarts it on the next enabled edge.
        assign w_start   = (r_act == '0) && w_pv_in;

        always_comb begin
            w_nxt_cnt  = r_cnt;
            w_nxt_act  = r_act;
            w_nxt_pv   = w_pv_in;
            w_nxt_tick = 1'b0;
            if (bus.iEN) begin
                if (w_wrap || w_start) begin
                    w_nxt_cnt  = '0;
                    w_nxt_tick = w_wrap;
                    if (w_pv_in) begin
                        w_nxt_act = w_pend_in;
                        w_nxt_pv  = 1'b0;
                    end
                end else if (r_act != '0) begin
                    w_nxt_cnt = r_cnt + ONE;
                end
            end
            // One extra bit keeps ceil(D/2) exact for D = 2^WIDE-1.
            w_nxt_half = ({1'b0, w_nxt_act} + ONE_X) >> 1;
            w_nxt_clk  = ({1'b0, w_nxt_cnt} < w_nxt_half);
        end

        always_ff @(posedge iCLK) begin
            if (iRST) begin
                r_cnt  <= '0;
                r_act  <= DEF;
                r_pend <= '0;
                r_pv   <= 1'b0;
                r_clk  <= (DEF != '0);
                r_tick <= 1'b0;
            end else begin
                r_cnt  <= w_nxt_cnt;
                r_act  <= w_nxt_act;
                r_pend <= w_pend_in;
                r_pv   <= w_nxt_pv;
                r_clk  <= w_nxt_clk;
                r_tick <= w_nxt_tick;
            end
        end

        assign bus.oCLK[c]  = r_clk;
        assign bus.oTICK[c] = r_tick;
    end
endmodule

// File: tb/tb_div_multi_ch.sv
// tb/tb_div_multi_ch.sv - scoreboard bench for div_multi_ch with hand-computed per-edge outputs
module tb_div_multi_ch;
    localparam int WIDE = 16;
    localparam int CH   = 4;

    logic iCLK = 1'b0;
    logic iRST = 1'b1;

    div_multi_ch_if #(.WIDE(WIDE), .CH(CH)) bus ();

    div_multi_ch #(.WIDE(WIDE), .CH(CH), .DEFAULT_DIV(2)) dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus.slave)
    );

    always #5 iCLK = ~iCLK;

    typedef struct packed {
        logic [CH-1:0] clk;
        logic [CH-1:0] tick;
        int            id;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   step_id = 0;
    bit   done = 1'b0;

    function automatic logic [CH*WIDE-1:0] mk(input logic [WIDE-1:0] d0, d1, d2, d3);
        return {d3, d2, d1, d0};
    endfunction

    // Drive inputs for the coming rising edge and queue the outputs expected right after it.
    task automatic step(input logic rst, input logic en, input logic [CH-1:0] ld,
                        input logic [CH*WIDE-1:0] div,
                        input logic [CH-1:0] eclk, input logic [CH-1:0] etick);
        exp_t e;
        @(negedge iCLK);
        iRST      = rst;
        bus.iEN   = en;
        bus.iLOAD = ld;
        bus.iDIV  = div;
        e.clk  = eclk;
        e.tick = etick;
        e.id   = step_id;
        step_id++;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge iCLK);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (bus.oCLK !== e.clk) begin
                    n_miss++;
                    $display("FAIL oclk step %0d: got %b expected %b", e.id, bus.oCLK, e.clk);
                end
                n_vec++;
                if (bus.oTICK !== e.tick) begin
                    n_miss++;
                    $display("FAIL otick step %0d: got %b expected %b", e.id, bus.oTICK, e.tick);
                end
            end
        end
    end

    initial begin : stim
        logic [CH*WIDE-1:0] z;
        z = '0;
        bus.iEN = 1'b0; bus.iLOAD = '0; bus.iDIV = '0;

        // reset with other inputs active must still give the default state
        step(1, 1, 4'b1111, mk(16'd9, 16'd9, 16'd9, 16'd9), 4'b1111, 4'b0000);
        // default D=2 on all channels
        step(0, 1, 0, z, 4'b0000, 4'b0000);
        step(0, 1, 0, z, 4'b1111, 4'b1111);
        step(0, 1, 0, z, 4'b0000, 4'b0000);
        step(0, 1, 0, z, 4'b1111, 4'b1111);
        // ch0 <- 3, ch1 <- 4, applied at the next wrap
        step(0, 1, 4'b0011, mk(16'd3, 16'd4, 16'd0, 16'd0), 4'b0000, 4'b0000);
        step(0, 1, 0, z, 4'b1111, 4'b1111);
        step(0, 1, 0, z, 4'b0011, 4'b0000);
        step(0, 1, 0, z, 4'b1100, 4'b1100);
        step(0, 1, 0, z, 4'b0001, 4'b0001);
        step(0, 1, 0, z, 4'b1111, 4'b1110);
        step(0, 1, 0, z, 4'b0010, 4'b0000);
        step(0, 1, 0, z, 4'b1101, 4'b1101);
        // reset, then ch0 D=4, load 6 at cnt=1 and 5 one cycle later
        step(1, 1, 0, z, 4'b1111, 4'b0000);
        step(0, 1, 4'b0001, mk(16'd4, 16'd0, 16'd0, 16'd0), 4'b0000, 4'b0000);
        step(0, 1, 0, z, 4'b1111, 4'b1111);
        step(0, 1, 0, z, 4'b0001, 4'b0000);
        step(0, 1, 4'b0001, mk(16'd6, 16'd0, 16'd0, 16'd0), 4'b1110, 4'b1110);
        step(0, 1, 4'b0001, mk(16'd5, 16'd0, 16'd0, 16'd0), 4'b0000, 4'b0000);
        step(0, 1, 0, z, 4'b1111, 4'b1111);
        step(0, 1, 0, z, 4'b0001, 4'b0000);
        step(0, 1, 0, z, 4'b1111, 4'b1110);
        step(0, 1, 0, z, 4'b0000, 4'b0000);
        step(0, 1, 0, z, 4'b1110, 4'b1110);
        step(0, 1, 0, z, 4'b0001, 4'b0001);
        // reset, ch0 D=1, then D=0 (coincident with wrap), then D=7 restart
        step(1, 1, 0, z, 4'b1111, 4'b0000);
        step(0, 1, 4'b0001, mk(16'd1, 16'd0, 16'd0, 16'd0), 4'b0000, 4'b0000);
        step(0, 1, 0, z, 4'b1111, 4'b1111);
        step(0, 1, 0, z, 4'b0001, 4'b0001);
        step(0, 1, 0, z, 4'b1111, 4'b1111);
        step(0, 1, 4'b0001, mk(16'd0, 16'd0, 16'd0, 16'd0), 4'b0000, 4'b0001);
        step(0, 1, 0, z, 4'b1110, 4'b1110);
        step(0, 1, 0, z, 4'b0000, 4'b0000);
        step(0, 1, 4'b0001, mk(16'd7, 16'd0, 16'd0, 16'd0), 4'b1111, 4'b1110);
        step(0, 1, 0, z, 4'b0001, 4'b0000);
        step(0, 1, 0, z, 4'b1111, 4'b1110);
        step(0, 1, 0, z, 4'b0001, 4'b0000);
        step(0, 1, 0, z, 4'b1110, 4'b1110);
        step(0, 1, 0, z, 4'b0000, 4'b0000);
        step(0, 1, 0, z, 4'b1110, 4'b1110);
        step(0, 1, 0, z, 4'b0001, 4'b0001);
        // freeze mid-period for 5 edges, just before ch1..ch3 would wrap
        step(0, 1, 0, z, 4'b1111, 4'b1110);
        step(0, 1, 0, z, 4'b0001, 4'b0000);
        for (int i = 0; i < 5; i++) step(0, 0, 0, z, 4'b0001, 4'b0000);
        step(0, 1, 0, z, 4'b1111, 4'b1110);
        step(0, 1, 0, z, 4'b0000, 4'b0000);
        step(0, 1, 0, z, 4'b1110, 4'b1110);
        // pending ch1 load discarded by reset
        step(0, 1, 4'b0010, mk(16'd0, 16'd9, 16'd0, 16'd0), 4'b0000, 4'b0000);
        step(1, 1, 0, z, 4'b1111, 4'b0000);
        step(0, 1, 0, z, 4'b0000, 4'b0000);
        step(0, 1, 0, z, 4'b1111, 4'b1111);
        step(0, 1, 0, z, 4'b0000, 4'b0000);
        step(0, 1, 0, z, 4'b1111, 4'b1111);
        // largest divisor on ch3: stays high well past the others' periods
        step(0, 1, 4'b1000, mk(16'd0, 16'd0, 16'd0, 16'hFFFF), 4'b0000, 4'b0000);
        step(0, 1, 0, z, 4'b1111, 4'b1111);
        step(0, 1, 0, z, 4'b1000, 4'b0000);
        step(0, 1, 0, z, 4'b1111, 4'b0111);

        repeat (3) @(posedge iCLK);
        #2;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin : watchdog
        #20000;
        if (!done) begin
            $display("FAIL timeout: bench did not complete, vectors %0d", n_vec);
            $fatal(1, "timeout");
        end
    end
endmodule
